// File: rtl/uart_program_loader.sv
// Boot-time program loader: 8N1 UART receiver feeding an FSM that assembles little-endian
// 32-bit words and writes them into instruction memory, preceded by a 4-byte word count.
module uart_program_loader #(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned BAUD      = 115_200,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        load_done,
  output logic        load_error,
  output logic [31:0] words_loaded
);

  localparam int unsigned ClksPerBit = CLK_FREQ / BAUD;
  localparam int unsigned CntW       = $clog2(ClksPerBit);
  localparam logic [CntW-1:0] BitEnd  = CntW'(ClksPerBit - 1);
  localparam logic [CntW-1:0] HalfEnd = CntW'(ClksPerBit / 2 - 1);

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
  typedef enum logic [1:0] {LdLen, LdData, LdDone, LdError} ld_state_e;

  logic            rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d, rx_prev_q, rx_prev_d;
  rx_state_e       rx_state_q, rx_state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            byte_valid, frame_err;

  ld_state_e       ld_state_q, ld_state_d;
  logic [1:0]      byte_cnt_q, byte_cnt_d;
  logic [31:0]     len_q, len_d, word_q, word_d, words_q, words_d;
  logic            we_q, we_d;
  logic [31:0]     addr_q, addr_d, wdata_q, wdata_d;

  // Receiver: sample mid-bit, counting from the first synchronised low of the start bit.
  always_comb begin
    rx_meta_d  = rx;
    rx_sync_d  = rx_meta_q;
    rx_prev_d  = rx_sync_q;
    rx_state_d = rx_state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RxStart;
          cnt_d      = '0;
        end
      end
      RxStart: begin
        if (cnt_q == HalfEnd) begin
          cnt_d      = '0;
          bit_idx_d  = '0;
          rx_state_d = rx_sync_q ? RxIdle : RxData;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      RxData: begin
        if (cnt_q == BitEnd) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          if (bit_idx_q == 3'd7) rx_state_d = RxStop;
          else bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      RxStop: begin
        if (cnt_q == BitEnd) begin
          cnt_d      = '0;
          rx_state_d = RxIdle;
          byte_valid = rx_sync_q;
          frame_err  = !rx_sync_q;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  always_comb begin
    ld_state_d = ld_state_q;
    byte_cnt_d = byte_cnt_q;
    len_d      = len_q;
    word_d     = word_q;
    words_d    = words_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    unique case (ld_state_q)
      LdLen: begin
        if (frame_err) begin
          ld_state_d = LdError;
        end else if (byte_valid) begin
          len_d      = {shift_q, len_q[31:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            if (len_d == 32'd0)                ld_state_d = LdDone;
            else if (len_d > 32'(MAX_WORDS))   ld_state_d = LdError;
            else                               ld_state_d = LdData;
          end
        end
      end
      LdData: begin
        if (frame_err) begin
          ld_state_d = LdError;
        end else if (byte_valid) begin
          word_d     = {shift_q, word_q[31:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = {words_q[29:0], 2'b00};
            wdata_d = word_d;
            words_d = words_q + 32'd1;
          end
        end
        // Finish one cycle after the final write is presented.
        if (we_q && words_q == len_q) ld_state_d = LdDone;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RxIdle;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      ld_state_q <= LdLen;
      byte_cnt_q <= '0;
      len_q      <= '0;
      word_q     <= '0;
      words_q    <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      rx_meta_q  <= rx_meta_d;
      rx_sync_q  <= rx_sync_d;
      rx_prev_q  <= rx_prev_d;
      rx_state_q <= rx_state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      ld_state_q <= ld_state_d;
      byte_cnt_q <= byte_cnt_d;
      len_q      <= len_d;
      word_q     <= word_d;
      words_q    <= words_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign load_done    = (ld_state_q == LdDone);
  assign load_error   = (ld_state_q == LdError);
  assign words_loaded = words_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader at 10 clocks per UART bit.
module tb_uart_program_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic        imem_we, load_done, load_error;
  logic [31:0] imem_addr, imem_wdata, words_loaded;

  int checks   = 0;
  int failures = 0;

  uart_program_loader #(
    .CLK_FREQ (1_000_000),
    .BAUD     (100_000),
    .MAX_WORDS(1024)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .load_done   (load_done),
    .load_error  (load_error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  // Write log and byte_valid pulse counter, sampled on the falling edge.
  logic [31:0] wr_addr [64];
  logic [31:0] wr_data [64];
  int          wr_cnt      = 0;
  int          bv_cnt      = 0;
  int          cyc         = 0;
  int          last_we_cyc = 0;
  int          done_cyc    = 0;
  logic        done_prev   = 1'b0;

  always @(negedge clk) begin
    cyc       <= cyc + 1;
    done_prev <= load_done;
    if (dut.byte_valid) bv_cnt <= bv_cnt + 1;
    if (imem_we) begin
      if (wr_cnt < 64) begin
        wr_addr[wr_cnt] <= imem_addr;
        wr_data[wr_cnt] <= imem_wdata;
      end
      wr_cnt      <= wr_cnt + 1;
      last_we_cyc <= cyc;
    end
    if (load_done && !done_prev) done_cyc <= cyc;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    tick(10);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(10);
    end
    rx = stop_bit;
    tick(10);
    rx = 1'b1;
    tick(2);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".we"}, {31'd0, imem_we}, 32'd0);
    check({tag, ".addr"}, imem_addr, 32'd0);
    check({tag, ".wdata"}, imem_wdata, 32'd0);
    check({tag, ".done"}, {31'd0, load_done}, 32'd0);
    check({tag, ".err"}, {31'd0, load_error}, 32'd0);
    check({tag, ".words"}, words_loaded, 32'd0);
  endtask

  task automatic run_and_check_two_words(input string tag);
    int base;
    base = wr_cnt;
    send_word(32'd2);
    send_word(32'h0010_0513);
    send_word(32'h0020_0593);
    tick(20);
    check({tag, ".nwr"}, 32'(wr_cnt - base), 32'd2);
    check({tag, ".addr0"}, wr_addr[base], 32'h0);
    check({tag, ".data0"}, wr_data[base], 32'h0010_0513);
    check({tag, ".addr1"}, wr_addr[base+1], 32'h4);
    check({tag, ".data1"}, wr_data[base+1], 32'h0020_0593);
    check({tag, ".done"}, {31'd0, load_done}, 32'd1);
    check({tag, ".err"}, {31'd0, load_error}, 32'd0);
    check({tag, ".words"}, words_loaded, 32'd2);
    check({tag, ".done_lat"}, 32'(done_cyc - last_we_cyc), 32'd1);
  endtask

  initial begin
    int base;
    int bv_base;

    tick(3);
    rst = 1'b0;
    tick(1);
    check_idle_outputs("reset");

    // Two-word program.
    run_and_check_two_words("two_words");

    // Empty program.
    do_reset();
    base = wr_cnt;
    send_word(32'd0);
    tick(20);
    check("empty.nwr", 32'(wr_cnt - base), 32'd0);
    check("empty.done", {31'd0, load_done}, 32'd1);
    check("empty.err", {31'd0, load_error}, 32'd0);
    check("empty.words", words_loaded, 32'd0);

    // Oversize length: MAX_WORDS+1.
    do_reset();
    base = wr_cnt;
    send_word(32'd1025);
    tick(20);
    check("oversize.err", {31'd0, load_error}, 32'd1);
    check("oversize.done", {31'd0, load_done}, 32'd0);
    check("oversize.nwr", 32'(wr_cnt - base), 32'd0);

    // Length exactly MAX_WORDS is accepted and waits for data.
    do_reset();
    send_word(32'd1024);
    tick(20);
    check("maxlen.err", {31'd0, load_error}, 32'd0);
    check("maxlen.done", {31'd0, load_done}, 32'd0);

    // Framing error on the second data byte.
    do_reset();
    base = wr_cnt;
    send_word(32'd1);
    send_byte(8'h13, 1'b1);
    send_byte(8'h05, 1'b0);
    send_byte(8'h10, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    tick(20);
    check("frame.err", {31'd0, load_error}, 32'd1);
    check("frame.done", {31'd0, load_done}, 32'd0);
    check("frame.nwr", 32'(wr_cnt - base), 32'd0);
    check("frame.words", words_loaded, 32'd0);

    // Short low glitch must not produce a byte.
    do_reset();
    bv_base = bv_cnt;
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(30);
    check("glitch.bytes", 32'(bv_cnt - bv_base), 32'd0);
    check("glitch.err", {31'd0, load_error}, 32'd0);
    send_word(32'd0);
    tick(20);
    check("glitch.done", {31'd0, load_done}, 32'd1);
    check("glitch.bytes_after", 32'(bv_cnt - bv_base), 32'd4);

    // Reset in the middle of word 0, then the full stream again.
    do_reset();
    send_word(32'd2);
    send_byte(8'h13, 1'b1);
    send_byte(8'h05, 1'b1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check_idle_outputs("midreset");
    tick(1);
    run_and_check_two_words("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
